lpddr5_bank_controller: RTL and testbench

Parametrised, banked LPDDR5 memory model with a built-in command scheduler. Accepts single-beat read/write requests over a valid/ready handshake and tracks one open row per bank, charging an activation penalty on row misses. Issues periodic all-bank refresh and enters power-down when `clk_en` drops. Sits between the system-side memory port and the behavioural array; it supersedes the flat, unbanked memory model.

---
 rtl/lpddr5_pkg.sv | 41 ++++
 rtl/lpddr5_refresh_timer.sv | 35 +++
 rtl/lpddr5_bank_controller.sv | 205 ++++++++++++++++++++
 tb/tb_lpddr5_bank_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr5_pkg.sv
// Shared definitions for the banked LPDDR5 controller model.
//   - state_e      : controller FSM states
//   - Def*         : default geometry and timing values
//   - addr_row/bank/col : split a request address laid out as {row, bank, col}
package lpddr5_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActivate,
    StRefresh,
    StPdown
  } state_e;

  localparam int unsigned DefAddrWidth   = 16;
  localparam int unsigned DefDataWidth   = 64;
  localparam int unsigned DefNumBanks    = 4;
  localparam int unsigned DefColWidth    = 6;
  localparam int unsigned DefTRcd        = 3;
  localparam int unsigned DefTRfc        = 8;
  localparam int unsigned DefTRefi       = 256;
  localparam int unsigned DefReadLatency = 2;

  // Address helpers work on a wide container; callers cast to their own widths.
  localparam int unsigned AddrCalcWidth = 64;
  typedef logic [AddrCalcWidth-1:0] addr_calc_t;

  function automatic addr_calc_t addr_col(addr_calc_t addr, int unsigned col_w);
    return addr & ((addr_calc_t'(1) << col_w) - addr_calc_t'(1));
  endfunction

  function automatic addr_calc_t addr_bank(addr_calc_t addr, int unsigned col_w,
                                           int unsigned bank_bits);
    return (addr >> col_w) & ((addr_calc_t'(1) << bank_bits) - addr_calc_t'(1));
  endfunction

  function automatic addr_calc_t addr_row(addr_calc_t addr, int unsigned col_w,
                                          int unsigned bank_bits);
    return addr >> (col_w + bank_bits);
  endfunction

endpackage

// File: rtl/lpddr5_refresh_timer.sv
// Refresh interval counter.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   cnt_en_i        : count this cycle (controller active)
//   clr_i           : clear the counter (refresh in progress)
//   refresh_due_o   : counter has reached T_REFI-1
module lpddr5_refresh_timer
  import lpddr5_pkg::*;
#(
  parameter int unsigned T_REFI = DefTRefi
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic refresh_due_o
);

  localparam int unsigned CntWidth = $clog2(T_REFI) + 1;

  logic [CntWidth-1:0] cnt_q;

  // Saturates once due, so a long activation cannot wrap the counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && !refresh_due_o) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign refresh_due_o = (cnt_q >= CntWidth'(T_REFI - 1));

endmodule

// File: rtl/lpddr5_bank_controller.sv
// Banked LPDDR5 memory model with a single-issue command scheduler.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   clk_en_i              : low requests power-down
//   req_valid_i/ready_o   : request handshake
//   req_write_i, req_addr_i, req_wdata_i, req_wmask_i : request payload
//   rsp_valid_o, rsp_rdata_o : read response, READ_LATENCY after the access
//   busy_refresh_o        : high while refreshing
// One row is tracked open per bank; a miss costs T_RCD cycles of activation.
module lpddr5_bank_controller
  import lpddr5_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned NUM_BANKS    = DefNumBanks,
  parameter int unsigned COL_WIDTH    = DefColWidth,
  parameter int unsigned T_RCD        = DefTRcd,
  parameter int unsigned T_RFC        = DefTRfc,
  parameter int unsigned T_REFI       = DefTRefi,
  parameter int unsigned READ_LATENCY = DefReadLatency
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    busy_refresh_o
);

  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
  localparam int unsigned ROW_WIDTH  = ADDR_WIDTH - BANK_BITS - COL_WIDTH;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_MAX    = (T_RCD > T_RFC) ? T_RCD : T_RFC;
  localparam int unsigned CNT_WIDTH  = $clog2(CNT_MAX + 1);

  // FSM and bank state
  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [NUM_BANKS-1:0]   bank_open_q;
  logic [ROW_WIDTH-1:0]   open_row_q [NUM_BANKS];

  // Request latched on a miss, replayed at the end of activation
  logic                   lat_write_q;
  logic [ADDR_WIDTH-1:0]  lat_addr_q;
  logic [DATA_WIDTH-1:0]  lat_wdata_q;
  logic [STRB_WIDTH-1:0]  lat_wmask_q;

  logic                   refresh_due;
  logic [BANK_BITS-1:0]   req_bank, lat_bank;
  logic [ROW_WIDTH-1:0]   req_row, lat_row;
  logic                   req_hit, req_fire, act_done;

  // Access port into the array (at most one access per cycle)
  logic                   acc_en;
  logic                   acc_write;
  logic [ADDR_WIDTH-1:0]  acc_addr;
  logic [DATA_WIDTH-1:0]  acc_wdata;
  logic [STRB_WIDTH-1:0]  acc_wmask;

  logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_WIDTH];

  logic [READ_LATENCY-1:0] rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q [READ_LATENCY];

  assign req_bank = BANK_BITS'(addr_bank(AddrCalcWidth'(req_addr_i), COL_WIDTH, BANK_BITS));
  assign req_row  = ROW_WIDTH'(addr_row(AddrCalcWidth'(req_addr_i), COL_WIDTH, BANK_BITS));
  assign lat_bank = BANK_BITS'(addr_bank(AddrCalcWidth'(lat_addr_q), COL_WIDTH, BANK_BITS));
  assign lat_row  = ROW_WIDTH'(addr_row(AddrCalcWidth'(lat_addr_q), COL_WIDTH, BANK_BITS));

  assign req_hit  = bank_open_q[req_bank] && (open_row_q[req_bank] == req_row);

  // Gated by rst_i so every output reads 0 while reset is held.
  assign req_ready_o = !rst_i && (state_q == StIdle) && clk_en_i && !refresh_due;
  assign req_fire    = req_valid_i && req_ready_o;
  assign act_done    = (state_q == StActivate) && (cnt_q == '0);

  assign busy_refresh_o = (state_q == StRefresh);

  lpddr5_refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cnt_en_i      ((state_q == StIdle) || (state_q == StActivate)),
    .clr_i         (state_q == StRefresh),
    .refresh_due_o (refresh_due)
  );

  // Hits go straight to the array; misses are replayed in the last activate cycle.
  always_comb begin
    acc_en    = 1'b0;
    acc_write = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_wmask = '0;
    if (req_fire && req_hit) begin
      acc_en    = 1'b1;
      acc_write = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_wmask = req_wmask_i;
    end else if (act_done) begin
      acc_en    = 1'b1;
      acc_write = lat_write_q;
      acc_addr  = lat_addr_q;
      acc_wdata = lat_wdata_q;
      acc_wmask = lat_wmask_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bank_open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        open_row_q[i] <= '0;
      end
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wmask_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (refresh_due) begin
            state_q <= StRefresh;
            cnt_q   <= CNT_WIDTH'(T_RFC - 1);
          end else if (!clk_en_i) begin
            state_q <= StPdown;
          end else if (req_fire && !req_hit) begin
            state_q     <= StActivate;
            cnt_q       <= CNT_WIDTH'(T_RCD - 1);
            lat_write_q <= req_write_i;
            lat_addr_q  <= req_addr_i;
            lat_wdata_q <= req_wdata_i;
            lat_wmask_q <= req_wmask_i;
          end
        end
        StActivate: begin
          if (cnt_q == '0) begin
            state_q               <= StIdle;
            bank_open_q[lat_bank] <= 1'b1;
            open_row_q[lat_bank]  <= lat_row;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        StRefresh: begin
          bank_open_q <= '0;
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        StPdown: begin
          // Every wake-up refreshes before serving requests again.
          if (clk_en_i) begin
            state_q <= StRefresh;
            cnt_q   <= CNT_WIDTH'(T_RFC - 1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Behavioural array: contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (acc_en && acc_write) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (acc_wmask[b]) begin
          mem_q[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline advances every cycle regardless of FSM state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      rd_valid_q[0] <= acc_en && !acc_write;
      rd_data_q[0]  <= mem_q[acc_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  assign rsp_valid_o = rd_valid_q[READ_LATENCY-1];
  assign rsp_rdata_o = rd_data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_lpddr5_bank_controller.sv
// Bench for lpddr5_bank_controller: directed scenarios followed by random traffic,
// all checked every cycle against a timestamp-based reference model.
module tb_lpddr5_bank_controller;

  localparam int TRcd  = 3;
  localparam int TRfc  = 8;
  localparam int TRefi = 256;
  localparam int Rl    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clk_en_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [15:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wmask_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        busy_refresh_o;

  always #5 clk_i = ~clk_i;

  lpddr5_bank_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clk_en_i       (clk_en_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_write_i    (req_write_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_wmask_i    (req_wmask_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .busy_refresh_o (busy_refresh_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle windows instead of states
  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [63:0] mask;
  } rsp_t;

  int          cyc = 0;
  int          act_cnt;    // active cycles since the last refresh
  int          ref_start;  // refresh occupies [ref_start, ref_end)
  int          ref_end;
  int          act_end;    // activation occupies (accept, act_end], access at act_end
  bit          in_pd;
  logic        pend_write;
  logic [15:0] pend_addr;
  logic [63:0] pend_wdata;
  logic [7:0]  pend_wmask;
  bit          open_m [4];
  int          row_m  [4];
  logic [63:0] mem_m  [int];
  logic [63:0] kn_m   [int];  // which bits of mem_m are known
  rsp_t        exp_q  [$];

  // Observation helpers
  bit          last_fire;
  logic [3:0]  pat;
  logic [63:0] last_rdata;
  int          busy_cnt = 0;
  int          rsp_cnt  = 0;
  int          fire_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    act_cnt   = 0;
    ref_start = 0;
    ref_end   = 0;
    act_end   = -1;
    in_pd     = 0;
    for (int i = 0; i < 4; i++) begin
      open_m[i] = 0;
      row_m[i]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] m);
    logic [63:0] cur;
    logic [63:0] kn;
    rsp_t        e;
    int          ai;
    ai  = int'(a);
    cur = mem_m.exists(ai) ? mem_m[ai] : 64'h0;
    kn  = kn_m.exists(ai) ? kn_m[ai] : 64'h0;
    if (w) begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) begin
          cur[b*8 +: 8] = d[b*8 +: 8];
          kn[b*8 +: 8]  = 8'hFF;
        end
      end
      mem_m[ai] = cur;
      kn_m[ai]  = kn;
    end else begin
      e.cyc  = cyc + Rl;
      e.data = cur;
      e.mask = kn;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_cycle();
    bit   refreshing;
    bit   activating;
    bit   idle;
    bit   due;
    logic exp_ready;
    int   a;
    int   bk;
    refreshing = (cyc >= ref_start) && (cyc < ref_end);
    activating = (cyc <= act_end);
    idle       = !refreshing && !activating && !in_pd;
    due        = (act_cnt >= TRefi - 1);
    exp_ready  = idle && clk_en_i && !due;
    chk("req_ready", {63'h0, req_ready_o}, {63'h0, exp_ready});
    chk("busy_refresh", {63'h0, busy_refresh_o}, {63'h0, refreshing});
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      chk("rsp_valid", {63'h0, rsp_valid_o}, 64'h1);
      chk("rsp_rdata", rsp_rdata_o & exp_q[0].mask, exp_q[0].data & exp_q[0].mask);
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid_idle", {63'h0, rsp_valid_o}, 64'h0);
    end

    if (refreshing) begin
      act_cnt = 0;
      for (int i = 0; i < 4; i++) open_m[i] = 0;
    end else if (!in_pd) begin
      act_cnt++;
    end

    if (activating && cyc == act_end) begin
      access(pend_write, pend_addr, pend_wdata, pend_wmask);
      bk         = (int'(pend_addr) >> 6) % 4;
      open_m[bk] = 1;
      row_m[bk]  = int'(pend_addr) >> 8;
    end

    if (idle) begin
      if (due) begin
        ref_start = cyc + 1;
        ref_end   = cyc + 1 + TRfc;
      end else if (!clk_en_i) begin
        in_pd = 1;
      end else if (req_valid_i) begin
        a  = int'(req_addr_i);
        bk = (a >> 6) % 4;
        if (open_m[bk] && row_m[bk] == (a >> 8)) begin
          access(req_write_i, req_addr_i, req_wdata_i, req_wmask_i);
        end else begin
          pend_write = req_write_i;
          pend_addr  = req_addr_i;
          pend_wdata = req_wdata_i;
          pend_wmask = req_wmask_i;
          act_end    = cyc + TRcd;
        end
      end
    end else if (in_pd && clk_en_i) begin
      in_pd     = 0;
      ref_start = cyc + 1;
      ref_end   = cyc + 1 + TRfc;
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk_i);
    if (rst_i) begin
      model_reset();
      chk("rst_req_ready", {63'h0, req_ready_o}, 64'h0);
      chk("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
      chk("rst_rsp_rdata", rsp_rdata_o, 64'h0);
      chk("rst_busy_refresh", {63'h0, busy_refresh_o}, 64'h0);
    end else begin
      model_cycle();
    end
    pat       = {pat[2:0], req_ready_o};
    last_fire = req_valid_i && req_ready_o;
    if (last_fire) fire_cnt++;
    if (busy_refresh_o) busy_cnt++;
    if (rsp_valid_o) begin
      rsp_cnt++;
      last_rdata = rsp_rdata_o;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [63:0] d,
                       input logic [7:0] m);
    int n;
    n           = 0;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    req_wmask_i = m;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 64);
    chk("issue_accepted", {63'h0, last_fire}, 64'h1);
    req_valid_i = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int b0;
    int r0;
    int f0;
    rst_i       = 1'b1;
    clk_en_i    = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wmask_i = '0;
    pat         = '0;
    last_rdata  = '0;
    model_reset();
    idle_ticks(2);
    rst_i = 1'b0;

    // 1: write miss then read hit
    issue(1'b1, 16'h1040, 64'h0123456789ABCDEF, 8'hFF);
    idle_ticks(4);
    chk("t1_write_miss_ready", {60'h0, pat}, 64'h1);
    r0 = rsp_cnt;
    issue(1'b0, 16'h1040, '0, '0);
    idle_ticks(2);
    chk("t1_read_hit_ready", {62'h0, pat[1:0]}, 64'h3);
    chk("t1_rsp_count", 64'(rsp_cnt - r0), 64'd1);
    chk("t1_rdata", last_rdata, 64'h0123456789ABCDEF);

    // 2: byte mask
    issue(1'b1, 16'h0005, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    issue(1'b1, 16'h0005, 64'h0, 8'h0F);
    issue(1'b0, 16'h0005, '0, '0);
    idle_ticks(2);
    chk("t2_masked_rdata", last_rdata, 64'hFFFFFFFF00000000);

    // 3: row conflict in bank 0
    issue(1'b0, 16'h0100, '0, '0);
    issue(1'b0, 16'h4100, '0, '0);
    idle_ticks(4);
    chk("t3_conflict_ready", {60'h0, pat}, 64'h1);

    // 4: stream hits through a refresh; refresh closes the row so one miss follows
    b0          = busy_cnt;
    f0          = fire_cnt;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 16'h4100;
    idle_ticks(300);
    req_valid_i = 1'b0;
    chk("t4_refresh_len", 64'(busy_cnt - b0), 64'd8);
    chk("t4_accepted", 64'(fire_cnt - f0), 64'd288);
    idle_ticks(4);

    // 5: power-down and wake-up refresh
    clk_en_i = 1'b0;
    idle_ticks(50);
    b0       = busy_cnt;
    clk_en_i = 1'b1;
    n        = 0;
    do begin
      tick();
      n++;
    end while (!pat[0] && n < 40);
    chk("t5_wake_latency", 64'(n), 64'd10);
    chk("t5_refresh_len", 64'(busy_cnt - b0), 64'd8);

    // 6: reset one cycle after a read miss is accepted
    r0 = rsp_cnt;
    issue(1'b0, 16'h00C0, '0, '0);
    rst_i = 1'b1;
    idle_ticks(2);
    rst_i = 1'b0;
    idle_ticks(8);
    chk("t6_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    issue(1'b0, 16'h00C0, '0, '0);
    idle_ticks(4);
    chk("t6_miss_after_reset", {60'h0, pat}, 64'h1);

    // Random traffic over a few rows/banks/columns to mix hits, misses and power-down
    for (int i = 0; i < 3000; i++) begin
      if (!req_valid_i || last_fire) begin
        req_valid_i = ($urandom_range(0, 3) != 0);
        req_write_i = 1'($urandom_range(0, 1));
        req_addr_i  = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 6) |
                          $urandom_range(0, 3));
        req_wdata_i = {$urandom, $urandom};
        req_wmask_i = 8'($urandom);
      end
      if (clk_en_i) begin
        if ($urandom_range(0, 199) == 0) clk_en_i = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        clk_en_i = 1'b1;
      end
      tick();
    end
    req_valid_i = 1'b0;
    clk_en_i    = 1'b1;
    idle_ticks(30);
    chk("drain_pending_rsp", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
